// File: rtl/rf_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_queue
//  Description : In-order write queue between the execute stage and the
//                register bank. Drains one queued result per cycle into the
//                bank write port and offers a combinational bypass lookup of
//                results that are queued but not yet written.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_write_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,        // asynchronous, active-low
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [ADDR_W-1:0]        res_addr,
  input  logic [DATA_W-1:0]        res_data,
  input  logic                     flush,
  input  logic                     rf_stall,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  lookup_idx;

  // Handshake and drain: no pass-through when full, nothing leaves during a flush.
  always_comb begin
    res_ready = (count_q < C_DEPTH);
    rf_write  = (count_q != '0) && !rf_stall && !flush;
    push      = res_valid && res_ready && !flush;
    pop       = rf_write;
    rf_addr   = (count_q != '0) ? mem_addr_q[rd_ptr_q] : '0;
    rf_data   = (count_q != '0) ? mem_data_q[rd_ptr_q] : '0;
    count     = count_q;
  end

  // Next-state for pointers, occupancy and storage; flush overrides everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_addr_d[wr_ptr_q] = res_addr;
        mem_data_d[wr_ptr_q] = res_data;
        wr_ptr_d             = wr_ptr_q + 1'b1;   // DEPTH is a power of two: wraps naturally
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Bypass lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (mem_addr_q[lookup_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data_q[lookup_idx];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_queue
//  Description : Self-checking bench for rf_write_queue. A queue scoreboard
//                predicts every bank write; scenario tasks check occupancy,
//                handshake, flush and lookup behaviour inline.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_write_queue;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              flush;
  logic              rf_stall;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [2:0]        count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              sb [$];
  logic [DATA_W-1:0] bank [32];
  bit                m_acc;
  bit                m_pop;
  ent_t              m_head;

  always #5 clk = ~clk;

  rf_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .flush(flush), .rf_stall(rf_stall),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count)
  );

  // Register bank model: captures whatever the queue writes.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else if (rf_write) begin
      bank[rf_addr] <= rf_data;
    end
  end

  // Scoreboard: predict acceptance from the model's own occupancy, pop on each write.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      m_acc = res_valid && !flush && (sb.size() < DEPTH);
      m_pop = (sb.size() != 0) && !rf_stall && !flush;
      n_vec++;
      if (rf_write !== m_pop) begin
        n_err++;
        $display("FAIL sb_rf_write t=%0t: got %b expected %b", $time, rf_write, m_pop);
      end
      if (m_pop) begin
        m_head = sb.pop_front();
        n_vec++;
        if (rf_addr !== m_head.a || rf_data !== m_head.d) begin
          n_err++;
          $display("FAIL sb_write_entry t=%0t: got addr %0d data %h expected addr %0d data %h",
                   $time, rf_addr, rf_data, m_head.a, m_head.d);
        end
      end
      if (flush) sb.delete();
      if (m_acc) sb.push_back({res_addr, res_data});
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 20 && count != 0; t++) drive_edge();
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL %s_drain: count %0d expected 0", name, count); end
  endtask

  task automatic test_reset();
    reset = 1'b0; res_valid = 1'b0; res_addr = '0; res_data = '0;
    flush = 1'b0; rf_stall = 1'b0; lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: %0d expected 0", count); end
    n_vec++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: %b expected 1", res_ready); end
    n_vec++; if (rf_write !== 1'b0) begin n_err++; $display("FAIL reset_write: %b expected 0", rf_write); end
    n_vec++; if (lookup_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: %b expected 0", lookup_hit); end
    n_vec++; if ({rf_addr, rf_data, lookup_data} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: addr %0d data %h ldata %h expected 0", rf_addr, rf_data, lookup_data);
    end
    // Fill three entries under stall, then pull reset low mid-cycle.
    drive_edge();
    rf_stall = 1'b1; res_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      res_addr = 5'(k + 1); res_data = 8'(8'hA0 + k);
      drive_edge();
    end
    res_valid = 1'b0; rf_stall = 1'b0;
    #1;
    n_vec++; if (count !== 3'd3 || rf_write !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: count %0d write %b expected 3/1", count, rf_write);
    end
    reset = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0 || rf_write !== 1'b0 || res_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_post: count %0d write %b ready %b expected 0/0/1", count, rf_write, res_ready);
    end
    drive_edge();
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive_edge();
    res_valid = 1'b1; res_addr = 5'd1; res_data = 8'h01;
    @(negedge clk);
    n_vec++; if (count !== 3'd0 || rf_write !== 1'b0) begin
      n_err++; $display("FAIL b2b_c0: count %0d write %b expected 0/0", count, rf_write);
    end
    drive_edge();
    res_addr = 5'd4; res_data = 8'h04;
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1 || rf_addr !== 5'd1 || rf_data !== 8'h01 || count !== 3'd1) begin
      n_err++; $display("FAIL b2b_c1: write %b addr %0d data %h count %0d expected 1/1/01/1", rf_write, rf_addr, rf_data, count);
    end
    drive_edge();
    res_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 8'h04 || count !== 3'd1) begin
      n_err++; $display("FAIL b2b_c2: write %b addr %0d data %h count %0d expected 1/4/04/1", rf_write, rf_addr, rf_data, count);
    end
    drive_edge();
    @(negedge clk);
    n_vec++; if (count !== 3'd0 || rf_write !== 1'b0) begin
      n_err++; $display("FAIL b2b_c3: count %0d write %b expected 0/0", count, rf_write);
    end
    n_vec++; if (bank[1] !== 8'h01 || bank[4] !== 8'h04) begin
      n_err++; $display("FAIL b2b_bank: r1 %h r4 %h expected 01/04", bank[1], bank[4]);
    end
  endtask

  task automatic test_stall_full();
    drive_edge();
    rf_stall = 1'b1; res_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      res_addr = 5'(8 + k); res_data = 8'(8'h30 + k);
      @(negedge clk);
      n_vec++; if (count !== 3'((k < 4) ? k : 4) || res_ready !== (k < 4)) begin
        n_err++; $display("FAIL stall_fill_%0d: count %0d ready %b expected %0d/%b", k, count, res_ready, (k < 4) ? k : 4, (k < 4));
      end
      drive_edge();
    end
    res_valid = 1'b0; rf_stall = 1'b0;
    @(negedge clk);
    n_vec++; if (count !== 3'd4 || res_ready !== 1'b0 || rf_write !== 1'b1) begin
      n_err++; $display("FAIL stall_release: count %0d ready %b write %b expected 4/0/1", count, res_ready, rf_write);
    end
    drive_edge();
    @(negedge clk);
    n_vec++; if (count !== 3'd3 || res_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_after_pop: count %0d ready %b expected 3/1", count, res_ready);
    end
    drain("stall");
  endtask

  task automatic test_lookup();
    drive_edge();
    rf_stall = 1'b1; res_valid = 1'b1;
    res_addr = 5'd3; res_data = 8'h55; drive_edge();
    res_addr = 5'd4; res_data = 8'h10; drive_edge();
    res_addr = 5'd4; res_data = 8'h20; drive_edge();
    res_valid = 1'b0; lookup_addr = 5'd4;
    @(negedge clk);
    n_vec++; if (lookup_hit !== 1'b1 || lookup_data !== 8'h20) begin
      n_err++; $display("FAIL lookup_young: hit %b data %h expected 1/20", lookup_hit, lookup_data);
    end
    lookup_addr = 5'd2;
    #1;
    n_vec++; if (lookup_hit !== 1'b0 || lookup_data !== 8'h00) begin
      n_err++; $display("FAIL lookup_miss: hit %b data %h expected 0/00", lookup_hit, lookup_data);
    end
    drive_edge();
    lookup_addr = 5'd3; rf_stall = 1'b0;
    @(negedge clk);
    n_vec++; if (rf_write !== 1'b1 || lookup_hit !== 1'b1 || lookup_data !== 8'h55) begin
      n_err++; $display("FAIL lookup_head_pop: write %b hit %b data %h expected 1/1/55", rf_write, lookup_hit, lookup_data);
    end
    drive_edge();
    rf_stall = 1'b1;
    @(negedge clk);
    n_vec++; if (count !== 3'd2 || lookup_hit !== 1'b0) begin
      n_err++; $display("FAIL lookup_after_pop: count %0d hit %b expected 2/0", count, lookup_hit);
    end
    drive_edge();
    rf_stall = 1'b0;
    drain("lookup");
  endtask

  task automatic test_flush();
    drive_edge();
    rf_stall = 1'b1; res_valid = 1'b1;
    res_addr = 5'd9;  res_data = 8'h99; drive_edge();
    res_addr = 5'd10; res_data = 8'hAA; drive_edge();
    res_addr = 5'd11; res_data = 8'hBB;
    flush = 1'b1; rf_stall = 1'b0;
    @(negedge clk);
    n_vec++; if (count !== 3'd2 || rf_write !== 1'b0 || res_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_cycle: count %0d write %b ready %b expected 2/0/1", count, rf_write, res_ready);
    end
    drive_edge();
    flush = 1'b0; res_valid = 1'b0; lookup_addr = 5'd11;
    @(negedge clk);
    n_vec++; if (count !== 3'd0 || rf_write !== 1'b0 || lookup_hit !== 1'b0) begin
      n_err++; $display("FAIL flush_after: count %0d write %b hit %b expected 0/0/0", count, rf_write, lookup_hit);
    end
    repeat (2) drive_edge();
  endtask

  task automatic test_simul_push_pop();
    drive_edge();
    rf_stall = 1'b1; res_valid = 1'b1;
    res_addr = 5'd16; res_data = 8'h40; drive_edge();
    res_addr = 5'd17; res_data = 8'h41; drive_edge();
    rf_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      res_addr = 5'(18 + k); res_data = 8'(8'h50 + k);
      @(negedge clk);
      n_vec++; if (count !== 3'd2 || rf_write !== 1'b1 || res_ready !== 1'b1) begin
        n_err++; $display("FAIL simul_%0d: count %0d write %b ready %b expected 2/1/1", k, count, rf_write, res_ready);
      end
      drive_edge();
    end
    res_valid = 1'b0;
    drain("simul");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_full();
    test_lookup();
    test_flush();
    test_simul_push_pop();
    repeat (2) drive_edge();
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d entries expected 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
